// File: rtl/opcode_escape_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : opcode_escape_sequencer
// Purpose  : Byte-serial instruction front-end. Strips legacy/REX prefixes,
//            recognises the 0F escape, classifies two-byte opcodes, captures
//            ModRM when needed and hands one descriptor per instruction to
//            the decoder over a valid/ready handshake.
// Options  : DECODE_REX_EN - treat 40..4F in the prefix phase as REX.
//            Undefined: 40..4F are one-byte opcodes and desc_rex stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module opcode_escape_sequencer (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       desc_valid,
    input  logic       desc_ready,
    output logic [7:0] desc_opcode,
    output logic       desc_two_byte,
    output logic [3:0] desc_pfx,
    output logic [3:0] desc_rex,
    output logic       desc_has_modrm,
    output logic [7:0] desc_modrm,
    output logic [2:0] desc_class,
    output logic [3:0] desc_len
);

    localparam logic [1:0] ST_PFX   = 2'd0;
    localparam logic [1:0] ST_ESC   = 2'd1;
    localparam logic [1:0] ST_MODRM = 2'd2;
    localparam logic [1:0] ST_OUT   = 2'd3;

    localparam logic [2:0] CLS_ILLEGAL  = 3'd0;
    localparam logic [2:0] CLS_VEC      = 3'd1;
    localparam logic [2:0] CLS_JCC      = 3'd2;
    localparam logic [2:0] CLS_MODRM_OP = 3'd3;
    localparam logic [2:0] CLS_SYS      = 3'd4;
    localparam logic [2:0] CLS_GROUP    = 3'd5;
    localparam logic [2:0] CLS_ONEBYTE  = 3'd6;

    // The 15th accepted byte of one instruction terminates it as illegal
    localparam logic [3:0] LEN_LAST_OK  = 4'd14;

    logic [1:0] state_q,     state_d;
    logic [7:0] opcode_q,    opcode_d;
    logic       two_byte_q,  two_byte_d;
    logic [3:0] pfx_q,       pfx_d;
    logic [3:0] rex_q,       rex_d;
    logic       has_modrm_q, has_modrm_d;
    logic [7:0] modrm_q,     modrm_d;
    logic [2:0] class_q,     class_d;
    logic [3:0] len_q,       len_d;

    logic       accept;
    logic       is_rex;
    logic [2:0] esc_class;

    // Second byte after 0F: map to its decode class
    function automatic logic [2:0] classify(input logic [7:0] b);
        logic [2:0] c;
        if (b inside {8'h04, 8'h0A, 8'h0C, 8'h0E, 8'h0F, [8'h19:8'h1E],
                      [8'h24:8'h27], 8'h36, [8'h38:8'h3F], 8'hA6, 8'hA7,
                      8'hB8, 8'hFF})
            c = CLS_ILLEGAL;
        else if (b inside {[8'h80:8'h8F]})
            c = CLS_JCC;
        else if (b inside {[8'h05:8'h09], 8'h0B, [8'h30:8'h35], 8'h37,
                           [8'hA0:8'hA2], [8'hA8:8'hAA], [8'hC8:8'hCF]})
            c = CLS_SYS;
        else if (b inside {8'h00, 8'h01, 8'hAE, 8'hB9, 8'hBA, 8'hC7})
            c = CLS_GROUP;
        else if (b inside {[8'h10:8'h17], [8'h28:8'h2F], [8'h50:8'h7F],
                           [8'hC2:8'hC6], [8'hD0:8'hFE]})
            c = CLS_VEC;
        else
            c = CLS_MODRM_OP;
        return c;
    endfunction

    assign in_ready   = (state_q != ST_OUT);
    assign desc_valid = (state_q == ST_OUT);
    assign accept     = in_valid && in_ready;
    assign esc_class  = classify(in_byte);

`ifdef DECODE_REX_EN
    assign is_rex = (in_byte[7:4] == 4'h4);
`else
    assign is_rex = 1'b0;
`endif

    // Next-state and per-instruction field update
    always_comb begin
        state_d     = state_q;
        opcode_d    = opcode_q;
        two_byte_d  = two_byte_q;
        pfx_d       = pfx_q;
        rex_d       = rex_q;
        has_modrm_d = has_modrm_q;
        modrm_d     = modrm_q;
        class_d     = class_q;
        len_d       = len_q;

        if (flush || ((state_q == ST_OUT) && desc_ready)) begin
            // Flush wins over everything, including a byte accepted this cycle
            state_d     = ST_PFX;
            opcode_d    = 8'h00;
            two_byte_d  = 1'b0;
            pfx_d       = 4'h0;
            rex_d       = 4'h0;
            has_modrm_d = 1'b0;
            modrm_d     = 8'h00;
            class_d     = CLS_ILLEGAL;
            len_d       = 4'h0;
        end else if (accept) begin
            len_d = len_q + 4'd1;
            if (len_q == LEN_LAST_OK) begin
                // Over-long instruction: swallow the byte and close it out
                class_d     = CLS_ILLEGAL;
                has_modrm_d = 1'b0;
                state_d     = ST_OUT;
            end else begin
                case (state_q)
                    ST_PFX: begin
                        case (in_byte)
                            8'hF0: begin pfx_d[0] = 1'b1; rex_d = 4'h0; end
                            8'h66: begin pfx_d[1] = 1'b1; rex_d = 4'h0; end
                            8'hF2: begin pfx_d[2] = 1'b1; rex_d = 4'h0; end
                            8'hF3: begin pfx_d[3] = 1'b1; rex_d = 4'h0; end
                            // Segment overrides: counted, not recorded
                            8'h2E, 8'h36, 8'h3E,
                            8'h26, 8'h64, 8'h65: rex_d = 4'h0;
                            8'h0F: begin
                                two_byte_d = 1'b1;
                                state_d    = ST_ESC;
                            end
                            default: begin
                                if (is_rex) begin
                                    rex_d = in_byte[3:0];
                                end else begin
                                    opcode_d = in_byte;
                                    class_d  = CLS_ONEBYTE;
                                    state_d  = ST_OUT;
                                end
                            end
                        endcase
                    end
                    ST_ESC: begin
                        opcode_d = in_byte;
                        class_d  = esc_class;
                        if ((esc_class == CLS_VEC) || (esc_class == CLS_MODRM_OP) ||
                            (esc_class == CLS_GROUP))
                            state_d = ST_MODRM;
                        else
                            state_d = ST_OUT;
                    end
                    ST_MODRM: begin
                        modrm_d     = in_byte;
                        has_modrm_d = 1'b1;
                        state_d     = ST_OUT;
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // State and descriptor registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_PFX;
            opcode_q    <= 8'h00;
            two_byte_q  <= 1'b0;
            pfx_q       <= 4'h0;
            rex_q       <= 4'h0;
            has_modrm_q <= 1'b0;
            modrm_q     <= 8'h00;
            class_q     <= CLS_ILLEGAL;
            len_q       <= 4'h0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            two_byte_q  <= two_byte_d;
            pfx_q       <= pfx_d;
            rex_q       <= rex_d;
            has_modrm_q <= has_modrm_d;
            modrm_q     <= modrm_d;
            class_q     <= class_d;
            len_q       <= len_d;
        end
    end

    assign desc_opcode    = opcode_q;
    assign desc_two_byte  = two_byte_q;
    assign desc_pfx       = pfx_q;
    assign desc_rex       = rex_q;
    assign desc_has_modrm = has_modrm_q;
    assign desc_modrm     = modrm_q;
    assign desc_class     = class_q;
    assign desc_len       = len_q;

endmodule
`default_nettype wire

// File: tb/tb_opcode_escape_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_opcode_escape_sequencer
// Purpose  : Directed self-checking bench for opcode_escape_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opcode_escape_sequencer;

    logic       clk;
    logic       reset_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       desc_valid;
    logic       desc_ready;
    logic [7:0] desc_opcode;
    logic       desc_two_byte;
    logic [3:0] desc_pfx;
    logic [3:0] desc_rex;
    logic       desc_has_modrm;
    logic [7:0] desc_modrm;
    logic [2:0] desc_class;
    logic [3:0] desc_len;

    int n_vec;
    int n_err;

    localparam logic [2:0] C_ILL = 3'd0;
    localparam logic [2:0] C_VEC = 3'd1;
    localparam logic [2:0] C_JCC = 3'd2;
    localparam logic [2:0] C_MOP = 3'd3;
    localparam logic [2:0] C_SYS = 3'd4;
    localparam logic [2:0] C_GRP = 3'd5;
    localparam logic [2:0] C_ONE = 3'd6;

    opcode_escape_sequencer u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_byte        (in_byte),
        .desc_valid     (desc_valid),
        .desc_ready     (desc_ready),
        .desc_opcode    (desc_opcode),
        .desc_two_byte  (desc_two_byte),
        .desc_pfx       (desc_pfx),
        .desc_rex       (desc_rex),
        .desc_has_modrm (desc_has_modrm),
        .desc_modrm     (desc_modrm),
        .desc_class     (desc_class),
        .desc_len       (desc_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present one byte and hold it until an edge where in_ready was high
    task automatic send(input logic [7:0] b);
        logic rdy;
        int   k;
        in_valid = 1'b1;
        in_byte  = b;
        for (k = 0; k < 20; k++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
        end
        if (k == 20) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic check_desc(input string tag, input logic [7:0] op, input logic tb,
                              input logic [3:0] pfx, input logic [3:0] rex,
                              input logic hm, input logic [7:0] mr,
                              input logic [2:0] cls, input logic [3:0] len);
        chk({tag, ".valid"}, {31'd0, desc_valid}, 32'd1);
        chk({tag, ".opcode"}, {24'd0, desc_opcode}, {24'd0, op});
        chk({tag, ".two_byte"}, {31'd0, desc_two_byte}, {31'd0, tb});
        chk({tag, ".pfx"}, {28'd0, desc_pfx}, {28'd0, pfx});
        chk({tag, ".rex"}, {28'd0, desc_rex}, {28'd0, rex});
        chk({tag, ".has_modrm"}, {31'd0, desc_has_modrm}, {31'd0, hm});
        if (hm) chk({tag, ".modrm"}, {24'd0, desc_modrm}, {24'd0, mr});
        chk({tag, ".class"}, {29'd0, desc_class}, {29'd0, cls});
        chk({tag, ".len"}, {28'd0, desc_len}, {28'd0, len});
    endtask

    task automatic consume();
        desc_ready = 1'b1;
        @(posedge clk);
        #1;
        desc_ready = 1'b0;
        chk("consume.valid", {31'd0, desc_valid}, 32'd0);
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset_n    = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_byte    = 8'h00;
        desc_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        // Reset state
        chk("rst.valid", {31'd0, desc_valid}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.opcode", {24'd0, desc_opcode}, 32'd0);
        chk("rst.pfx", {28'd0, desc_pfx}, 32'd0);
        chk("rst.class", {29'd0, desc_class}, 32'd0);
        chk("rst.len", {28'd0, desc_len}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 0F A2: descriptor the cycle after the second byte
        send(8'h0F);
        chk("cpuid.early", {31'd0, desc_valid}, 32'd0);
        send(8'hA2);
        check_desc("cpuid", 8'hA2, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, C_SYS, 4'd2);
        consume();

        // 66 F3 0F AF C1 with consumer stalled for three cycles
        send(8'h66); send(8'hF3); send(8'h0F); send(8'hAF); send(8'hC1);
        check_desc("imul", 8'hAF, 1'b1, 4'b1010, 4'h0, 1'b1, 8'hC1, C_MOP, 4'd5);
        in_valid = 1'b1;
        in_byte  = 8'h90;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("hold.in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold.modrm", {24'd0, desc_modrm}, 32'hC1);
            chk("hold.len", {28'd0, desc_len}, 32'd5);
        end
        in_valid = 1'b0;
        check_desc("imul_held", 8'hAF, 1'b1, 4'b1010, 4'h0, 1'b1, 8'hC1, C_MOP, 4'd5);
        consume();

        // Back-to-back with consumer always ready
        desc_ready = 1'b1;
        send(8'h0F); send(8'h85);
        check_desc("jcc", 8'h85, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, C_JCC, 4'd2);
        send(8'h0F); send(8'hC7); send(8'h08);
        check_desc("grp", 8'hC7, 1'b1, 4'h0, 4'h0, 1'b1, 8'h08, C_GRP, 4'd3);
        @(posedge clk);
        #1;
        desc_ready = 1'b0;
        chk("b2b.drained", {31'd0, desc_valid}, 32'd0);

        // Assorted classes and prefixes
        send(8'h0F); send(8'h58); send(8'hC0);
        check_desc("vec", 8'h58, 1'b1, 4'h0, 4'h0, 1'b1, 8'hC0, C_VEC, 4'd3);
        consume();
        send(8'h0F); send(8'h19);
        check_desc("ill19", 8'h19, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, C_ILL, 4'd2);
        consume();
        send(8'h2E); send(8'h90);
        check_desc("seg", 8'h90, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, C_ONE, 4'd2);
        consume();
        send(8'hF0); send(8'hF2); send(8'hF0); send(8'h90);
        check_desc("lockrep", 8'h90, 1'b0, 4'b0101, 4'h0, 1'b0, 8'h00, C_ONE, 4'd4);
        consume();

`ifdef DECODE_REX_EN
        send(8'h48); send(8'h0F); send(8'hB6); send(8'hC0);
        check_desc("rex", 8'hB6, 1'b1, 4'h0, 4'h8, 1'b1, 8'hC0, C_MOP, 4'd4);
        consume();
        send(8'h48); send(8'h66); send(8'h0F); send(8'hB6); send(8'hC0);
        check_desc("rex_clr", 8'hB6, 1'b1, 4'b0010, 4'h0, 1'b1, 8'hC0, C_MOP, 4'd5);
        consume();
`else
        send(8'h48);
        check_desc("norex", 8'h48, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, C_ONE, 4'd1);
        consume();
`endif

        // Fourteen 66 prefixes then 0F: 15th byte closes as illegal
        for (int i = 0; i < 14; i++) send(8'h66);
        chk("long.pre", {31'd0, desc_valid}, 32'd0);
        send(8'h0F);
        chk("long.valid", {31'd0, desc_valid}, 32'd1);
        chk("long.class", {29'd0, desc_class}, {29'd0, C_ILL});
        chk("long.len", {28'd0, desc_len}, 32'd15);
        chk("long.has_modrm", {31'd0, desc_has_modrm}, 32'd0);
        chk("long.pfx", {28'd0, desc_pfx}, 32'b0010);
        consume();

        // Flush in MODRM, with a byte offered in the same cycle
        send(8'h0F); send(8'h10);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_byte  = 8'hC0;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("flush.valid", {31'd0, desc_valid}, 32'd0);
        chk("flush.in_ready", {31'd0, in_ready}, 32'd1);
        chk("flush.len", {28'd0, desc_len}, 32'd0);
        chk("flush.two_byte", {31'd0, desc_two_byte}, 32'd0);

        // Asynchronous reset mid-ESC
        send(8'h0F);
        reset_n = 1'b0;
        #2;
        chk("areset.len", {28'd0, desc_len}, 32'd0);
        chk("areset.two_byte", {31'd0, desc_two_byte}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("areset.valid", {31'd0, desc_valid}, 32'd0);
        send(8'h90);
        check_desc("after", 8'h90, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, C_ONE, 4'd1);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/opcode_escape_sequencer.md
# opcode_escape_sequencer

Byte-serial instruction front-end sitting between the fetch byte stream and the opcode decode tables. It strips legacy and REX prefixes, recognises the 0F two-byte escape, classifies the two-byte opcode, and captures a ModRM byte when the opcode requires one. It then hands one descriptor per instruction to the downstream decoder over a valid/ready handshake.

## Interface
- No parameters.
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous redirect; discards in-flight instruction and held descriptor
- in_valid  in  1  in_byte valid
- in_ready  out  1  byte accepted when in_valid && in_ready
- in_byte  in  8  instruction byte
- desc_valid  out  1  descriptor held
- desc_ready  in  1  consumer accepts descriptor
- desc_opcode  out  8  opcode byte (second byte if escaped)
- desc_two_byte  out  1  0F escape seen
- desc_pfx  out  4  {F3, F2, 66, lock F0}
- desc_rex  out  4  REX.WRXB (0 if none)
- desc_has_modrm  out  1  desc_modrm valid
- desc_modrm  out  8  captured ModRM
- desc_class  out  3  0 ILLEGAL, 1 VEC, 2 JCC, 3 MODRM_OP, 4 SYS, 5 GROUP, 6 ONEBYTE
- desc_len  out  4  bytes consumed for this descriptor

## Operation
- States: PFX, ESC, MODRM, OUT.
- PFX: F0/F2/F3/66 set the matching desc_pfx bit. 2E/36/3E/26/64/65 are consumed and counted without being recorded. 0F goes to ESC. Any other byte is a one-byte opcode: class ONEBYTE, has_modrm 0, go to OUT.
- ESC: classify the byte b and latch it into desc_opcode.
  - ILLEGAL: 04, 0A, 0C, 0E, 0F, 19–1E, 24–27, 36, 38, 39, 3A, 3B–3F, A6, A7, B8 (JMPE), FF.
  - JCC: 80–8F.
  - SYS (no ModRM): 05–09, 0B, 30–35, 37, A0–A2, A8–AA, C8–CF.
  - GROUP: 00, 01, AE, B9, BA, C7.
  - VEC: 10–17, 28–2F, 50–7F, C2–C6, D0–FE.
  - MODRM_OP: all remaining codes.
  - Classes VEC, MODRM_OP and GROUP go to MODRM. All other classes go to OUT.
- MODRM: capture the byte into desc_modrm, set has_modrm, go to OUT.
- OUT: desc_valid=1 and in_ready=0. On desc_ready, clear all per-instruction fields and go to PFX.
- Length counter: 4 bits, increments on every accepted byte. If a 15th byte would be accepted before reaching OUT, that byte is consumed, class is forced to ILLEGAL, has_modrm is 0, and desc_len=15.
- A duplicate prefix sets an already-set bit; this is not an error.
- flush has priority over every other event. It returns the block to PFX with all fields cleared, and any byte accepted in the same cycle is dropped.

## Timing
- Reset values:
  - state is PFX.
  - desc_valid is 0.
  - in_ready is 1.
  - All desc_* fields are 0.
- in_ready = (state != OUT). It is combinational from state only, never from in_valid.
- Each state consumes at most one byte per cycle. desc_valid rises the cycle after the final byte is accepted.
- Example latency: a prefix-free 0F xx ModRM instruction accepted on consecutive cycles 0–2 gives desc_valid at cycle 3.
- Descriptor fields are stable while desc_valid && !desc_ready.
- If desc_ready arrives in the OUT cycle, the next byte can be accepted on the following cycle. This gives at most one bubble per instruction.
- If in_valid is low, the current state is held. There is no timeout.
- Reset asserted mid-instruction clears everything asynchronously. No partial descriptor is ever emitted.

## Configuration
- DECODE_REX_EN defined:
  - In PFX, 40–4F are a REX prefix and load desc_rex from the low nibble.
  - A legacy prefix following REX clears desc_rex, so REX must be the last prefix to take effect.
- Undefined:
  - 40–4F are one-byte opcodes (class ONEBYTE), and desc_rex is tied to 0.

## Test plan
- 0F A2 → one descriptor: opcode A2, two_byte 1, class SYS, has_modrm 0, len 2, desc_valid at cycle 2.
- 66 F3 0F AF C1 → pfx 4'b1010, class MODRM_OP, modrm C1, len 5. Hold desc_ready low 3 cycles: fields stable and in_ready 0.
- 0F 85 then 0F C7 08 back-to-back with desc_ready=1 → first descriptor JCC, no ModRM; second GROUP, modrm 08.
- With DECODE_REX_EN: 48 0F B6 C0 → rex 8, class MODRM_OP, len 4. Also 48 66 0F B6 C0 → rex 0.
- Fourteen 66 bytes, then 0F → 15th byte consumed, class ILLEGAL, len 15.
- flush during MODRM state, then reset_n pulse mid-ESC → no descriptor emitted, next 90 yields a ONEBYTE descriptor with len 1.
